// File: rtl/first_nios2_system_sysinfo_pkg.sv
// Shared register-map offsets, CONTROL bit indices and byte-lane helper
// for the sysinfo Avalon-MM slave.
package first_nios2_system_sysinfo_pkg;

  localparam logic [3:0] OFF_ID   = 4'd0;
  localparam logic [3:0] OFF_TS   = 4'd1;
  localparam logic [3:0] OFF_UPLO = 4'd2;
  localparam logic [3:0] OFF_UPHI = 4'd3;
  localparam logic [3:0] OFF_CTRL = 4'd4;
  localparam logic [3:0] OFF_SCR  = 4'd8;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLEAR  = 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/first_nios2_system_sysinfo_uptime.sv
// 64-bit free-running uptime counter with freeze, clear and a high-word
// snapshot taken whenever the low word is read.
module first_nios2_system_sysinfo_uptime (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        freeze,
  input  logic        clear,
  input  logic        snap_en,
  output logic [63:0] cnt,
  output logic [31:0] snap_hi
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      snap_hi <= '0;
    end else begin
      // clear takes priority over counting
      if (clear)        cnt <= '0;
      else if (!freeze) cnt <= cnt + 64'd1;
      if (snap_en) snap_hi <= cnt[63:32];
    end
  end

endmodule

// File: rtl/first_nios2_system_sysinfo.sv
// System info slave: ID/timestamp constants, uptime counter, CONTROL and
// scratch registers behind a fixed one-cycle read latency.
module first_nios2_system_sysinfo
  import first_nios2_system_sysinfo_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_SCRATCH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic                             freeze;
  logic [NUM_SCRATCH-1:0][31:0]     scratch;
  logic [63:0]                      cnt;
  logic [31:0]                      snap_hi;
  logic [31:0]                      rd_mux;
  logic                             wr_ctrl;
  logic                             clear;

  assign wr_ctrl = write && (address == OFF_CTRL) && byteenable[0];
  assign clear   = wr_ctrl && writedata[CTRL_CLEAR];

  first_nios2_system_sysinfo_uptime u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .freeze  (freeze),
    .clear   (clear),
    .snap_en (read && (address == OFF_UPLO)),
    .cnt     (cnt),
    .snap_hi (snap_hi)
  );

  // A CLEAR write is a command: it pulses the clear and leaves FREEZE as is,
  // so a frozen counter can be zeroed without restarting it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      freeze <= 1'b0;
    else if (wr_ctrl && !writedata[CTRL_CLEAR])
      freeze <= writedata[CTRL_FREEZE];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else begin
      for (int k = 0; k < NUM_SCRATCH; k++)
        if (write && (address == OFF_SCR + 4'(k)))
          scratch[k] <= be_merge(scratch[k], writedata, byteenable);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      OFF_ID:   rd_mux = ID_VALUE;
      OFF_TS:   rd_mux = TIMESTAMP;
      OFF_UPLO: rd_mux = cnt[31:0];
      OFF_UPHI: rd_mux = snap_hi;
      OFF_CTRL: rd_mux = {31'b0, freeze};
      default: begin
        for (int k = 0; k < NUM_SCRATCH; k++)
          if (address == OFF_SCR + 4'(k)) rd_mux = scratch[k];
      end
    endcase
  end

  // rd_mux sees pre-write register values, so read+write returns old data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysinfo.sv
// Randomised and directed bench for the sysinfo slave against a cycle model
// of the register map kept in plain variables.
module tb_first_nios2_system_sysinfo;

  localparam logic [31:0] ID = 32'h569D_7A5E;
  localparam logic [31:0] TS = 32'h1234_5678;
  localparam int          NS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  first_nios2_system_sysinfo #(
    .ID_VALUE(ID), .TIMESTAMP(TS), .NUM_SCRATCH(NS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [63:0] m_cnt;
  logic [31:0] m_snap;
  logic [31:0] m_rd;
  logic        m_rdv;
  logic        m_frz;
  logic [31:0] m_scr [NS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return ID;
    if (ai == 1) return TS;
    if (ai == 2) return m_cnt[31:0];
    if (ai == 3) return m_snap;
    if (ai == 4) return {31'b0, m_frz};
    if (ai >= 8 && ai < 8 + NS) return m_scr[ai-8];
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_cnt = '0; m_snap = '0; m_rd = '0; m_rdv = 1'b0; m_frz = 1'b0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  task automatic m_edge(input logic r, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    logic frz_old, clr;
    int ai;
    ai = int'(a);
    frz_old = m_frz;
    clr = 1'b0;
    if (r) begin
      m_rd = m_read(a);
      if (ai == 2) m_snap = m_cnt[63:32];
    end
    m_rdv = r;
    if (w) begin
      if (ai == 4 && be[0]) begin
        if (d[1]) clr = 1'b1;
        else      m_frz = d[0];
      end
      if (ai >= 8 && ai < 8 + NS)
        for (int i = 0; i < 4; i++)
          if (be[i]) m_scr[ai-8][8*i +: 8] = d[8*i +: 8];
    end
    if (clr)           m_cnt = '0;
    else if (!frz_old) m_cnt = m_cnt + 64'd1;
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    read = r; write = w; address = a; writedata = d; byteenable = be;
    @(posedge clock);
    m_edge(r, w, a, d, be);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    chk("rdv", {63'b0, readdatavalid}, {63'b0, m_rdv});
    chk("rdata", {32'b0, readdata}, {32'b0, m_rd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] v1;
    m_reset();
    #2;
    chk("rst_rdata", {32'b0, readdata}, 64'h0);
    chk("rst_rdv", {63'b0, readdatavalid}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // constants
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    chk("id", {32'b0, readdata}, 64'h569D_7A5E);
    step(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    chk("ts", {32'b0, readdata}, 64'h1234_5678);
    idle(1);
    chk("rdv_idle", {63'b0, readdatavalid}, 64'h0);

    // low-word rollover and snapshot
    force dut.u_uptime.cnt = 64'h0000_0000_FFFF_FFFF;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_uptime.cnt;
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    chk("uplo_ffff", {32'b0, readdata}, 64'hFFFF_FFFF);
    idle(4);
    step(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    chk("uphi_snap", {32'b0, readdata}, 64'h0);

    // freeze, then clear while frozen
    step(1'b0, 1'b1, 4'd4, 32'h1, 4'hF);
    idle(10);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    v1 = readdata;
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    chk("frozen_eq", {32'b0, readdata}, {32'b0, v1});
    step(1'b0, 1'b1, 4'd4, 32'h2, 4'hF);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    chk("clr_le1", {63'b0, (readdata <= 32'd1)}, 64'h1);
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    chk("ctrl_frz", {32'b0, readdata}, 64'h1);
    step(1'b0, 1'b1, 4'd4, 32'hFFFF_FFFC, 4'hF);
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    chk("ctrl_hi0", {32'b0, readdata}, 64'h0);

    // scratch byte enables, RO write, unmapped offset
    step(1'b0, 1'b1, 4'd9, 32'hAABB_CCDD, 4'b0101);
    step(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    chk("scr_be", {32'b0, readdata}, 64'h00BB_00DD);
    step(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF);
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    chk("id_ro", {32'b0, readdata}, 64'h569D_7A5E);
    step(1'b1, 1'b0, 4'd15, 32'h0, 4'h0);
    chk("off15", {32'b0, readdata}, 64'h0);
    step(1'b0, 1'b1, 4'd8, 32'h1234_5678, 4'h0);
    step(1'b1, 1'b1, 4'd8, 32'hCAFE_F00D, 4'hF);
    chk("rw_old", {32'b0, readdata}, 64'h0);
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0);
    chk("rw_new", {32'b0, readdata}, 64'hCAFE_F00D);

    // random traffic
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));

    // reset in the cycle after a read
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("abort_rdv", {63'b0, readdatavalid}, 64'h0);
    chk("abort_rdata", {32'b0, readdata}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    chk("rst_uphi", {32'b0, readdata}, 64'h0);
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    chk("rst_ctrl", {32'b0, readdata}, 64'h0);
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0);
    chk("rst_scr0", {32'b0, readdata}, 64'h0);
    step(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    chk("rst_scr1", {32'b0, readdata}, 64'h0);
    step(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/first_nios2_system_sysinfo.md
FIRST_NIOS2_SYSTEM_SYSINFO -- requirements
Module: first_nios2_system_sysinfo

Interface
REQ-001 Parameter ID_VALUE, default 32'h0000_0000: system ID word returned at offset 0.
REQ-002 Parameter TIMESTAMP, default 32'h0000_0000: generation timestamp returned at offset 1.
REQ-003 Parameter NUM_SCRATCH, default 2, legal range 1..8: number of read/write scratch words at offsets 8..8+NUM_SCRATCH-1.
REQ-004 clock  input  1  sole clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  4  Avalon-MM word offset.
REQ-007 read  input  1  Avalon-MM read strobe, one cycle per transfer.
REQ-008 write  input  1  Avalon-MM write strobe, one cycle per transfer.
REQ-009 writedata  input  32  write data.
REQ-010 byteenable  input  4  per-byte write enable; bit n enables writedata[8n+7:8n].
REQ-011 readdata  output  32  registered read data.
REQ-012 readdatavalid  output  1  high for exactly one cycle when readdata is valid.

Function
REQ-013 The register map SHALL be:
- 0: ID (RO)
- 1: TIMESTAMP (RO)
- 2: UPTIME_LO (RO)
- 3: UPTIME_HI (RO, snapshot)
- 4: CONTROL (RW)
- 8+k: SCRATCH[k] (RW)
REQ-014 All other offsets SHALL read 0 and SHALL ignore writes.
REQ-015 Read latency SHALL be fixed at 1: read asserted in cycle N SHALL produce readdata and readdatavalid=1 in cycle N+1.
REQ-016 When no read was issued in the previous cycle, readdatavalid SHALL be 0 and readdata SHALL hold its last value.
REQ-017 A 64-bit uptime counter SHALL increment by 1 every cycle unless CONTROL.FREEZE (bit 0) is 1.
REQ-018 The uptime counter SHALL wrap from 2^64-1 to 0 with no flag.
REQ-019 A read of UPTIME_LO SHALL return counter[31:0] as sampled in the read cycle, and SHALL capture counter[63:32] from the same cycle into the UPTIME_HI snapshot.
REQ-020 A read of UPTIME_HI SHALL return the snapshot and SHALL NOT update it.
REQ-021 CONTROL bit 1 (CLEAR) SHALL be write-1-to-pulse: the counter SHALL be 0 in the cycle after the write, and the bit SHALL always read 0.
REQ-022 When CLEAR and an increment coincide, CLEAR SHALL win.
REQ-023 CONTROL bits 31:2 SHALL read 0.
REQ-024 Writes SHALL honour byteenable for CONTROL and SCRATCH; byteenable=0 SHALL leave the target register unchanged.
REQ-025 Writes to RO offsets SHALL have no effect.
REQ-026 When read and write are asserted together at the same offset, the write SHALL take effect and readdata SHALL return the pre-write value.

Reset
REQ-027 While reset_n=0, the following SHALL be 0, asynchronously: uptime counter, UPTIME_HI snapshot, CONTROL, all SCRATCH words, readdata, readdatavalid.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer: no readdatavalid pulse after deassertion, and no write takes effect.
REQ-029 Counting SHALL start in the first cycle after reset_n deasserts.

Structure
REQ-030 The offset constants (OFF_ID=0, OFF_TS=1, OFF_UPLO=2, OFF_UPHI=3, OFF_CTRL=4, OFF_SCR=8) and CONTROL bit indices SHALL live in a shared package, first_nios2_system_sysinfo_pkg.
REQ-031 The 64-bit counter with freeze, clear and snapshot SHALL be a sub-module, first_nios2_system_sysinfo_uptime.
REQ-032 Address decode, registers and the read mux SHALL be in the top module.

Verification
REQ-033 Reset, then read offsets 0,1 with ID_VALUE=32'h569D_7A5E and TIMESTAMP=32'h1234_5678 -> readdata 32'h569D_7A5E, then 32'h1234_5678, each with readdatavalid one cycle after read.
REQ-034 Force the counter to 64'h0000_0000_FFFF_FFFF, read UPTIME_LO in that cycle, then read UPTIME_HI 5 cycles later -> 32'hFFFF_FFFF, then 32'h0000_0000 (the snapshot, not the live value 1).
REQ-035 Write CONTROL=1, wait 10 cycles, read UPTIME_LO twice -> equal values; then write CONTROL=2 -> next UPTIME_LO read returns a value of 1 or less, and CONTROL reads 1.
REQ-036 Write SCRATCH[1]=32'hAABBCCDD with byteenable 4'b0101 over prior value 0 -> read returns 32'h00BB00DD; a write to offset 0 leaves ID unchanged; a read of offset 15 returns 0.
REQ-037 Assert reset_n=0 in the cycle after a read -> readdatavalid stays 0 after release, and all registers read 0.
